rgb_level_scan: RTL and testbench
=================================

Name: rgb_level_scan

Overview:
- Upstream stage of the 7-segment digit scan mux.
- Holds three 4-bit colour levels (R, G, B), edited by three push buttons: select, up and down.
- Generates the 2-bit digit-slot `control` that steps the scan mux through blank, R, G and B at a fixed refresh rate.
- All outputs are registered and drive the scan mux directly.

Parameters:
- SCAN_DIV, 50000: clock cycles each digit slot is held; must be ≥ 2.
- DEB_LEN, 4: consecutive synchronized-high samples required to accept a press; must be ≥ 2.
- MAX_LEVEL, 15: saturation ceiling for every level; must be ≤ 15.

Ports:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- btn_sel  input  1  raw, asynchronous button; cycles the channel being edited.
- btn_up  input  1  raw, asynchronous button; increments the selected level.
- btn_down  input  1  raw, asynchronous button; decrements the selected level.
- control  output  2  digit slot: 00 blank, 01 R, 10 G, 11 B.
- R  output  4  red level.
- G  output  4  green level.
- B  output  4  blue level.
- sel  output  2  channel being edited: 00 R, 01 G, 10 B. Value 11 is never driven.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - control=00, R=G=B=0, sel=00.
  - Scan counter, synchronizers, debounce registers and edge registers all cleared.
- Reset mid-operation:
  - A press in progress is discarded.
  - After release of rst_n, a button already held high must go low and high again before it produces a pulse.
- Button path (identical per button):
  - Two-flop synchronizer.
  - DEB_LEN-bit shift register fed by the synchronizer output.
  - Debounced level register goes high when all DEB_LEN bits are 1 and low when all are 0; otherwise it holds.
  - One-cycle pulse = debounced level AND NOT its previous-cycle value.
- Latency: with a button stable high from before clock edge 1, the pulse is high in the cycle after edge DEB_LEN+3. The affected register updates on edge DEB_LEN+4.
- Glitches shorter than DEB_LEN cycles produce no pulse. A held button produces exactly one pulse; there is no auto-repeat.
- sel pulse: sel steps 00→01→10→00.
- up pulse: selected level +1, saturating at MAX_LEVEL.
- down pulse: selected level −1, saturating at 0.
- Simultaneous events:
  - up and down pulses in the same cycle: no level change.
  - sel pulse in the same cycle as an up/down pulse: the level update uses the old sel, and sel advances on the same edge.
- Unselected levels never change.
- Scan generator:
  - Counter runs 0..SCAN_DIV-1 and wraps to 0.
  - On the edge where the counter wraps, control advances 00→01→10→11→00.
  - Each slot lasts exactly SCAN_DIV cycles; the first advance to 01 occurs SCAN_DIV edges after reset release.
- Scanning is free-running and independent of the button path.
- R/G/B may change mid-slot; the scan mux simply shows the new value from that cycle on.
- Arithmetic: levels are 4-bit unsigned. The saturation compare happens before the add/subtract, so the value never wraps.

Decomposition:
- Shared package (rgb_scan_pkg):
  - Slot codes: SLOT_BLANK=2'b00, SLOT_R=2'b01, SLOT_G=2'b10, SLOT_B=2'b11.
  - Channel codes: CH_R=2'b00, CH_G=2'b01, CH_B=2'b10.
  - LEVEL_W=4.
- Sub-module btn_conditioner (params DEB_LEN; ports clk, rst_n, btn_raw, pulse):
  - Contains the synchronizer, debounce and one-pulse logic.
  - Instantiated three times.
- The top contains the sel/level registers and the scan counter.

Test Plan:
- Bench parameters: SCAN_DIV=4, DEB_LEN=4, MAX_LEVEL=15 unless stated.
- Scan sequence: release reset, hold buttons low, run 20 cycles → control=00 for cycles 0-3, then 01, 10, 11, 00, each held exactly 4 cycles.
- Debounce and latency: btn_up high for 3 cycles then low → R stays 0. Hold btn_up high → R=1 exactly on edge 8 after the first high sample, and stays 1 while the button is held for 50 cycles.
- Select and saturation: press sel once (sel=01), press up 17 times → G=15, R=0, B=0. Then press down 16 times → G=0, with no wrap to 15.
- Simultaneous events: with sel=00 and R=5, assert up and down pulses on the same edge → R=5. Then sel and up on the same edge → R=6, sel=01.
- Sel wrap: press sel three times from reset → sel 01, 10, 00; sel never equals 11.
- Reset mid-operation: R=7, sel=10, control=11; assert rst_n low mid-cycle → all outputs 0 immediately, without waiting for a clock edge. Keep btn_up held through release → no increment until the button is released and pressed again.

Source files
------------

// File: rtl/rgb_scan_pkg.sv
// rtl/rgb_scan_pkg.sv - shared codes, level type and step helpers for rgb_level_scan
package rgb_scan_pkg;

  localparam int LEVEL_W = 4;

  typedef logic [LEVEL_W-1:0] level_t;

  typedef enum logic [1:0] {
    SLOT_BLANK = 2'b00,
    SLOT_R     = 2'b01,
    SLOT_G     = 2'b10,
    SLOT_B     = 2'b11
  } slot_t;

  typedef enum logic [1:0] {
    CH_R = 2'b00,
    CH_G = 2'b01,
    CH_B = 2'b10
  } ch_t;

  // Compare before the add/subtract so a level can never wrap.
  function automatic level_t level_step(level_t v, logic up, logic dn, level_t max);
    level_t r;
    r = v;
    if (up && !dn && (v < max)) begin
      r = v + level_t'(1);
    end else if (dn && !up && (v != '0)) begin
      r = v - level_t'(1);
    end
    return r;
  endfunction

  function automatic ch_t ch_next(ch_t c);
    ch_t r;
    case (c)
      CH_R:    r = CH_G;
      CH_G:    r = CH_B;
      default: r = CH_R;
    endcase
    return r;
  endfunction

  function automatic slot_t slot_next(slot_t s);
    slot_t r;
    case (s)
      SLOT_BLANK: r = SLOT_R;
      SLOT_R:     r = SLOT_G;
      SLOT_G:     r = SLOT_B;
      default:    r = SLOT_BLANK;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rgb_level_scan_if.sv
// rtl/rgb_level_scan_if.sv - button inputs and scan-mux outputs of rgb_level_scan
interface rgb_level_scan_if;
  import rgb_scan_pkg::*;

  logic               btn_sel;
  logic               btn_up;
  logic               btn_down;
  logic [1:0]         control;
  logic [LEVEL_W-1:0] R;
  logic [LEVEL_W-1:0] G;
  logic [LEVEL_W-1:0] B;
  logic [1:0]         sel;

  modport master (
    output btn_sel, btn_up, btn_down,
    input  control, R, G, B, sel
  );

  modport slave (
    input  btn_sel, btn_up, btn_down,
    output control, R, G, B, sel
  );

endinterface

// File: rtl/rgb_level_scan_btn_conditioner.sv
// rtl/rgb_level_scan_btn_conditioner.sv - synchronize, debounce and one-pulse a raw button
module btn_conditioner #(
  parameter int DEB_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  logic [1:0]         sync_q;
  logic [DEB_LEN-1:0] shift_q;
  logic [DEB_LEN+1:0] fill_q;
  logic               level_q;
  logic               prev_q;
  logic               armed_q;

  // armed_q stays low until a genuine all-low window is observed after reset,
  // so a button held through reset cannot fire until it is released first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      shift_q <= '0;
      fill_q  <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      shift_q <= {shift_q[DEB_LEN-2:0], sync_q[1]};
      fill_q  <= {fill_q[DEB_LEN:0], 1'b1};
      prev_q  <= level_q;
      if (&shift_q) begin
        level_q <= 1'b1;
      end else if (~|shift_q) begin
        level_q <= 1'b0;
      end
      if (fill_q[DEB_LEN+1] && (~|shift_q)) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign pulse = level_q & ~prev_q & armed_q;

endmodule

// File: rtl/rgb_level_scan.sv
// rtl/rgb_level_scan.sv - RGB level editor and digit-slot generator feeding the scan mux
module rgb_level_scan
  import rgb_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_LEN   = 4,
  parameter int MAX_LEVEL = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  rgb_level_scan_if.slave  bus
);

  localparam int     CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam level_t LVL_MAX = level_t'(MAX_LEVEL);

  logic p_sel, p_up, p_dn;

  btn_conditioner #(.DEB_LEN(DEB_LEN)) u_sel (
    .clk(clk), .rst_n(rst_n), .btn_raw(bus.btn_sel), .pulse(p_sel)
  );
  btn_conditioner #(.DEB_LEN(DEB_LEN)) u_up (
    .clk(clk), .rst_n(rst_n), .btn_raw(bus.btn_up), .pulse(p_up)
  );
  btn_conditioner #(.DEB_LEN(DEB_LEN)) u_dn (
    .clk(clk), .rst_n(rst_n), .btn_raw(bus.btn_down), .pulse(p_dn)
  );

  logic [CNT_W-1:0] cnt_q;
  logic             wrap;
  slot_t            slot_q, slot_d;

  assign wrap = (cnt_q == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      slot_q <= SLOT_BLANK;
    end else begin
      cnt_q  <= wrap ? '0 : cnt_q + CNT_W'(1);
      slot_q <= slot_d;
    end
  end

  always_comb begin
    slot_d = slot_q;
    if (wrap) begin
      slot_d = slot_next(slot_q);
    end
  end

  always_comb begin
    bus.control = slot_q;
  end

  ch_t    sel_q;
  level_t r_q, g_q, b_q;

  // Level update uses the sel value from before this edge, even if sel advances too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= CH_R;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else begin
      case (sel_q)
        CH_R:    r_q <= level_step(r_q, p_up, p_dn, LVL_MAX);
        CH_G:    g_q <= level_step(g_q, p_up, p_dn, LVL_MAX);
        CH_B:    b_q <= level_step(b_q, p_up, p_dn, LVL_MAX);
        default: ;
      endcase
      if (p_sel) begin
        sel_q <= ch_next(sel_q);
      end
    end
  end

  assign bus.R   = r_q;
  assign bus.G   = g_q;
  assign bus.B   = b_q;
  assign bus.sel = sel_q;

endmodule

// File: tb/tb_rgb_level_scan.sv
// tb/tb_rgb_level_scan.sv - self-checking bench for rgb_level_scan
module tb_rgb_level_scan;

  localparam int SCAN_DIV  = 4;
  localparam int DEB_LEN   = 4;
  localparam int MAX_LEVEL = 15;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  int   exp_lvl [3];
  int   exp_sel;

  rgb_level_scan_if bus ();

  rgb_level_scan #(
    .SCAN_DIV(SCAN_DIV), .DEB_LEN(DEB_LEN), .MAX_LEVEL(MAX_LEVEL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    exp_lvl[0] = 0;
    exp_lvl[1] = 0;
    exp_lvl[2] = 0;
    exp_sel    = 0;
  endtask

  // Level step acts on the channel selected before the sel press takes effect.
  task automatic model_step(input bit s, input bit u, input bit d);
    if (u && !d && exp_lvl[exp_sel] < MAX_LEVEL) exp_lvl[exp_sel]++;
    if (d && !u && exp_lvl[exp_sel] > 0)         exp_lvl[exp_sel]--;
    if (s) exp_sel = (exp_sel + 1) % 3;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".R"}, int'(bus.R), exp_lvl[0]);
    chk({tag, ".G"}, int'(bus.G), exp_lvl[1]);
    chk({tag, ".B"}, int'(bus.B), exp_lvl[2]);
    chk({tag, ".sel"}, int'(bus.sel), exp_sel);
  endtask

  task automatic press(input bit s, input bit u, input bit d, input int hold, input string tag);
    bus.btn_sel  = s;
    bus.btn_up   = u;
    bus.btn_down = d;
    tick(hold);
    bus.btn_sel  = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    tick(DEB_LEN + 5);
    if (hold >= DEB_LEN) model_step(s, u, d);
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int found;
    total        = 0;
    bad          = 0;
    bus.btn_sel  = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    model_reset();

    // Scan sequence straight after reset release
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("scan.control", int'(bus.control), (k / SCAN_DIV) % 4);
      if (k == 0) check_all("reset");
      @(posedge clk);
    end
    #1;
    tick(DEB_LEN + 4);

    // Short glitch rejected
    press(1'b0, 1'b1, 1'b0, DEB_LEN - 1, "glitch");

    // Latency: update lands on edge DEB_LEN+4 after the first high sample
    bus.btn_up = 1'b1;
    for (int k = 1; k <= DEB_LEN + 4; k++) begin
      tick(1);
      chk("latency.R", int'(bus.R), (k >= DEB_LEN + 4) ? 1 : 0);
    end
    tick(50);
    chk("held.R", int'(bus.R), 1);
    bus.btn_up = 1'b0;
    tick(DEB_LEN + 5);
    model_step(1'b0, 1'b1, 1'b0);
    check_all("held");

    // Select G, saturate up then down
    press(1'b1, 1'b0, 1'b0, DEB_LEN + 1, "selG");
    for (int i = 0; i < 17; i++) press(1'b0, 1'b1, 1'b0, DEB_LEN, "upG");
    chk("satG.hi", int'(bus.G), 15);
    for (int i = 0; i < 16; i++) press(1'b0, 1'b0, 1'b1, DEB_LEN, "dnG");
    chk("satG.lo", int'(bus.G), 0);

    // Simultaneous events with sel=R, R=5
    press(1'b1, 1'b0, 1'b0, DEB_LEN, "selB");
    press(1'b1, 1'b0, 1'b0, DEB_LEN, "selR");
    for (int i = 0; i < 4; i++) press(1'b0, 1'b1, 1'b0, DEB_LEN + 2, "upR");
    chk("sim.pre", int'(bus.R), 5);
    press(1'b0, 1'b1, 1'b1, DEB_LEN + 1, "updn");
    chk("sim.updn", int'(bus.R), 5);
    press(1'b1, 1'b1, 1'b0, DEB_LEN + 1, "selup");
    chk("sim.selup.R", int'(bus.R), 6);
    chk("sim.selup.sel", int'(bus.sel), 1);

    // Sel wrap from reset
    do_reset();
    tick(DEB_LEN + 4);
    for (int i = 0; i < 3; i++) begin
      press(1'b1, 1'b0, 1'b0, DEB_LEN, "selwrap");
      chk("selwrap.seq", int'(bus.sel), (i + 1) % 3);
    end

    // Reset mid-operation with btn_up held through release
    for (int i = 0; i < 7; i++) press(1'b0, 1'b1, 1'b0, DEB_LEN, "pre7");
    press(1'b1, 1'b0, 1'b0, DEB_LEN, "pre.sel");
    press(1'b1, 1'b0, 1'b0, DEB_LEN, "pre.sel");
    found = 0;
    for (int k = 0; k < 4 * SCAN_DIV + 4 && found == 0; k++) begin
      if (bus.control == 2'b11) found = 1;
      else tick(1);
    end
    chk("midrst.slotB", found, 1);
    check_all("midrst.pre");
    #2;
    bus.btn_up = 1'b1;
    rst_n      = 1'b0;
    #1;
    model_reset();
    chk("midrst.control", int'(bus.control), 0);
    check_all("midrst.async");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(30);
    check_all("midrst.held");
    bus.btn_up = 1'b0;
    tick(DEB_LEN + 5);
    check_all("midrst.release");
    press(1'b0, 1'b1, 1'b0, DEB_LEN, "midrst.repress");

    // Randomized presses, biased to reach saturation
    for (int n = 0; n < 60; n++) begin
      int  m;
      int  hold;
      bit  s, u, d;
      m    = $urandom_range(0, 9);
      s    = (m == 0) || (m == 7);
      u    = (m >= 1 && m <= 4) || (m == 7) || (m == 8);
      d    = (m == 5) || (m == 6) || (m == 8) || (m == 9);
      hold = ($urandom_range(0, 5) == 0) ? $urandom_range(1, DEB_LEN - 1)
                                         : $urandom_range(DEB_LEN, DEB_LEN + 6);
      press(s, u, d, hold, "rand");
      chk("rand.sel_valid", (bus.sel == 2'b11) ? 1 : 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
